// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner for DIGITS hex digits.
// The scan runs from a prescaled tick. Each digit slot is split into
// 2^DIM_W PWM sub-steps, and sub-step 0 is always kept dark.
// Display data is double-buffered: a load goes into staging, and staging
// is copied to the active set only at a frame boundary.
// Optional feature: define SEG_SCAN_LAMP_TEST_EN to add the lamp_test input.
// While lamp_test is high, every scanned slot is driven fully lit.
module seg_scan_ctrl #(
    parameter int DIGITS      = 6,
    parameter int TICK_DIV    = 50,
    parameter int DIM_W       = 4,
    parameter int SEL_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   show_data,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_lz,
    input  logic [DIM_W-1:0]      brightness,
`ifdef SEG_SCAN_LAMP_TEST_EN
    input  logic                  lamp_test,
`endif
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF  = (SEL_ACT_LOW != 0) ? '1 : '0;
    localparam logic [7:0]        SEG_OFF  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    logic [PRE_W-1:0]    presc;
    logic [DIM_W-1:0]    sub;
    logic [IDX_W-1:0]    idx;
    logic                tick;
    logic                slot_end;
    logic                frame_wrap;

    logic [4*DIGITS-1:0] stg_data;
    logic [DIGITS-1:0]   stg_dp;
    logic                stg_blz;
    logic [4*DIGITS-1:0] act_data;
    logic [DIGITS-1:0]   act_dp;
    logic                act_blz;
    logic                pending;

    logic [DIGITS-1:0]   lz_vec;
    logic [3:0]          nib;
    logic [7:0]          pat_on;
    logic [7:0]          lit_pat;
    logic                lit;
    logic [DIGITS-1:0]   one_hot;
    logic [DIGITS-1:0]   sel_d;
    logic [7:0]          seg_d;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    assign tick        = (presc == PRE_LAST);
    assign slot_end    = tick && (sub == '1);
    assign frame_wrap  = slot_end && (idx == IDX_LAST);
    assign frame_start = frame_wrap;

    // Prescaler, PWM sub-step and digit index counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            sub   <= '0;
            idx   <= '0;
        end else begin
            if (tick) presc <= '0;
            else      presc <= presc + 1'b1;
            if (tick) sub <= sub + 1'b1;
            if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Staging/active double buffer: active only changes on a frame boundary.
    // A load coinciding with the boundary keeps pending set, so it is applied
    // at the following frame rather than the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_data <= '0;
            stg_dp   <= '0;
            stg_blz  <= 1'b0;
            act_data <= '0;
            act_dp   <= '0;
            act_blz  <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (load) begin
                stg_data <= show_data;
                stg_dp   <= dp_mask;
                stg_blz  <= blank_lz;
            end
            if (frame_wrap && pending) begin
                act_data <= stg_data;
                act_dp   <= stg_dp;
                act_blz  <= stg_blz;
            end
            if (load)            pending <= 1'b1;
            else if (frame_wrap) pending <= 1'b0;
        end
    end

    // Leading-zero map: digit i is zero-run if it and all higher digits are 0
    always_comb begin
        logic run;
        run    = 1'b1;
        lz_vec = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            int unsigned i;
            i         = DIGITS - 1 - k;
            run       = run & (act_data[4*i +: 4] == 4'h0);
            lz_vec[i] = run;
        end
        lz_vec[0] = 1'b0;
    end

    // Segment pattern for the current slot, PWM gate and output polarity
    always_comb begin
        nib     = act_data[4*int'(idx) +: 4];
        pat_on  = {act_dp[idx], (act_blz && lz_vec[idx]) ? 7'h00 : seg7(nib)};
        lit     = (sub != '0) && (sub <= brightness);
        lit_pat = lit ? pat_on : 8'h00;
`ifdef SEG_SCAN_LAMP_TEST_EN
        if (lamp_test) lit_pat = 8'hFF;
`endif
        one_hot = DIGITS'(1) << idx;
        sel_d   = (SEL_ACT_LOW != 0) ? ~one_hot : one_hot;
        seg_d   = (SEG_ACT_LOW != 0) ? ~lit_pat : lit_pat;
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= SEL_OFF;
            seg <= SEG_OFF;
        end else begin
            sel <= sel_d;
            seg <= seg_d;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment scanner: drives DIGITS digits from one packed hex word.
- Features: per-digit decimal point, leading-zero blanking, PWM brightness, ghost-guard blanking and tear-free frame-synchronous data load.
- Runs on the system clock with an internal scan prescaler.
- Sits between the status/measurement logic and the board digit/segment pins.

Parameters:
- DIGITS, 6: number of digits; show_data is 4*DIGITS bits wide.
- TICK_DIV, 50: clk cycles per PWM sub-step (must be 1 or more).
- DIM_W, 4: brightness width; one digit slot lasts 2^DIM_W sub-steps.
- SEL_ACT_LOW, 1: 1 = sel outputs active-low, 0 = active-high.
- SEG_ACT_LOW, 1: 1 = seg outputs active-low, 0 = active-high.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- show_data, in, 4*DIGITS: hex nibbles; nibble i drives digit i, with digit 0 = [3:0] = rightmost.
- load, in, 1: one-cycle strobe to capture show_data, dp_mask and blank_lz into staging.
- dp_mask, in, DIGITS: bit i lights the decimal point of digit i.
- blank_lz, in, 1: suppress leading zeros.
- brightness, in, DIM_W: 0 = dark, 2^DIM_W-1 = maximum.
- sel, out, DIGITS: one-hot digit enable (polarity per SEL_ACT_LOW).
- seg, out, 8: segments, bit order {dp,g,f,e,d,c,b,a} (polarity per SEG_ACT_LOW).
- frame_start, out, 1: one-cycle pulse when the scan returns to digit 0.

Behaviour:
- Reset (async, rst_n=0):
  - Clock and scan: prescaler=0, sub-step counter=0, digit index=0.
  - Data registers: staging, active and pending are all 0.
  - Outputs: sel all inactive, seg all inactive, frame_start=0.
- Prescaler:
  - Counts 0..TICK_DIV-1; wraps to 0 and asserts internal tick.
- Sub-step counter (DIM_W bits):
  - Advances on tick.
  - When it wraps from 2^DIM_W-1 to 0, the digit index advances.
- Digit index:
  - Counts 0..DIGITS-1 and wraps to 0.
  - The cycle it wraps to 0 is the frame boundary; frame_start=1 in that cycle only.
- Data path (double-buffered):
  - load=1: staging <= inputs, pending <= 1. A repeated load overwrites staging.
  - Frame boundary with pending=1: active <= staging (the pre-edge staging value), pending <= 0.
  - load in the same cycle as a frame boundary: the old staging goes active; the new load stays pending until the next frame.
  - Active data never changes mid-frame.
- Decode, active-high pattern before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - dp bit 7 = active dp_mask[index].
- Leading-zero blanking (active blank_lz=1):
  - Digit i is blanked if it and every higher digit are 0.
  - Digit 0 is never blanked.
  - A blanked digit outputs pattern 00, but its dp is still honoured.
- Output timing:
  - sel and seg are registered and update together one clk after the internal index/sub-step state.
  - sel = one-hot of the index, constant for the whole slot.
  - seg = pattern when 1 <= sub-step <= brightness; otherwise all inactive.
  - Sub-step 0 is always dark (ghost guard).
  - brightness=0 gives a permanently dark display; maximum brightness gives a duty of (2^DIM_W-1)/2^DIM_W.
- brightness is sampled live each cycle; it is not double-buffered.
- Polarity: apply per the parameters after decode; inactive = all ones when active-low.
- Reset asserted mid-frame: all state clears immediately; the scan restarts at digit 0 with blank data.

Optional Feature:
- Macro SEG_SCAN_LAMP_TEST_EN.
- When defined:
  - Adds input port lamp_test (1 bit).
  - While lamp_test=1, every scanned slot outputs pattern FF at full duty (sub-step 0 included).
  - This overrides data, blanking and brightness; scanning continues.
  - On release, normal output resumes on the next clk.
- When undefined:
  - No port, no override logic.
  - Behaviour is identical to lamp_test=0.

Test Plan:
- Reset and scan: reset, then TICK_DIV=2, DIM_W=2, DIGITS=6.
  - Expect sel active-low walking 111110, 111101, ..., 011111, each held 8 clk.
  - Expect frame_start pulses every 48 clk; seg=FF during reset.
- Decode and load: load show_data=0x0123AF, dp_mask=000100, brightness=3.
  - After the next frame_start: digit0 seg=~71, digit1 seg=~77, digit2 seg=~4F with dp low.
  - Sub-step 0 of each slot has seg=FF.
- Leading-zero blanking: load 0x000050, blank_lz=1.
  - Expect digits 5..2 seg=FF, digit1=~6D, digit0=~3F.
  - Then load 0x000000: digit0 shows ~3F, all others FF.
- Tear-free load: load 0x111111 mid-frame.
  - Current frame keeps the old data; the new value appears from the frame_start onward.
  - Then load 0x222222 coincident with frame_start: that frame shows 1s, the following frame shows 2s.
- Brightness: brightness=0 gives seg always FF; brightness=1 gives pattern active for exactly 1 sub-step per slot.
  - Verify the count of active cycles per slot = brightness*TICK_DIV.
- Reset mid-frame: assert rst_n low during digit 3.
  - Outputs inactive immediately; after release, the scan starts at digit 0 showing ~3F.
